// File: rtl/cpri_rx_unpack.sv
// rtl/cpri_rx_unpack.sv - CPRI RX chip unpacker: header strip, payload FIFO, RE serializer
// Consumes chip-addressed 64-bit words and emits two 16/16 I/Q RE samples per payload word.
module cpri_rx_unpack #(
  parameter int FIFO_DEPTH   = 32,
  parameter int AFULL_MARGIN = 12,
  parameter int HDR_WORDS    = 4,
  parameter int CHIP_LAST    = 95
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_tvalid,
  input  logic [63:0] i_tx_data,
  input  logic [6:0]  i_tx_addr,
  input  logic        i_tx_last,
  input  logic [31:0] i_fft_agc,
  output logic        o_rd_en,
  input  logic        i_re_rdy,
  output logic        o_re_vld,
  output logic [31:0] o_re_data,
  output logic [7:0]  o_re_idx,
  output logic        o_re_first,
  output logic        o_re_last,
  output logic [6:0]  o_slot_idx,
  output logic [3:0]  o_symb_idx,
  output logic [31:0] o_agc,
  output logic        o_seq_err,
  output logic        o_ovf,
  output logic [15:0] o_err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [6:0]  ADDR_LAST    = 7'(CHIP_LAST);
  localparam logic [6:0]  ADDR_HDR_END = 7'(HDR_WORDS - 1);
  localparam logic [6:0]  ADDR_PAY0    = 7'(HDR_WORDS);
  localparam logic [AW:0] CNT_DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_AFULL    = (AW+1)'(FIFO_DEPTH - AFULL_MARGIN);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_RESYNC} state_t;

  typedef struct packed {
    logic [6:0]  slot;
    logic [3:0]  symb;
    logic [31:0] agc;
    logic        first;
    logic        last;
    logic [63:0] data;
  } entry_t;

  state_t        state, state_n;
  logic [6:0]    exp_addr, exp_n;
  logic [6:0]    slot_q, slot_n;
  logic [3:0]    symb_q, symb_n;
  logic          seq_err_n, ovf_n;
  logic          addr_ok;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head, wr_entry;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, wr, pop, load;

  logic          phase;
  logic [6:0]    k, k_eff;

  assign empty = (count == '0);
  assign full  = (count == CNT_DEPTH);
  assign head  = mem[rd_ptr];
  assign load  = ~o_re_vld | i_re_rdy;
  assign pop   = load & ~empty & phase;
  assign k_eff = head.first ? 7'd0 : k;

  // A word is in sequence only if its address matches and its last flag agrees with it.
  assign addr_ok = (i_tx_addr == exp_addr) && (i_tx_last == (i_tx_addr == ADDR_LAST));

  assign wr_entry = {slot_q, symb_q, i_fft_agc, (i_tx_addr == ADDR_PAY0),
                     (i_tx_addr == ADDR_LAST), i_tx_data};

  always_comb begin
    state_n   = state;
    exp_n     = exp_addr;
    slot_n    = slot_q;
    symb_n    = symb_q;
    wr        = 1'b0;
    seq_err_n = 1'b0;
    ovf_n     = 1'b0;
    case (state)
      S_IDLE, S_RESYNC: begin
        if (i_tvalid && i_tx_addr == 7'd0) begin
          state_n = S_HDR;
          exp_n   = 7'd1;
        end
      end
      S_HDR, S_PAY: begin
        if (i_tvalid) begin
          if (!addr_ok) begin
            seq_err_n = 1'b1;
            if (i_tx_addr == 7'd0) begin
              state_n = S_HDR;
              exp_n   = 7'd1;
            end else begin
              state_n = S_RESYNC;
            end
          end else if (state == S_HDR) begin
            exp_n = exp_addr + 7'd1;
            if (i_tx_addr == 7'd3) begin
              slot_n = i_tx_data[18:12];
              symb_n = i_tx_data[11:8];
            end
            if (i_tx_addr == ADDR_HDR_END) state_n = S_PAY;
          end else if (full && !pop) begin
            // Drop the rest of the chip rather than resume it with a hole.
            ovf_n   = 1'b1;
            state_n = S_RESYNC;
          end else begin
            wr = 1'b1;
            if (i_tx_addr == ADDR_LAST) begin
              state_n = S_HDR;
              exp_n   = 7'd0;
            end else begin
              exp_n = exp_addr + 7'd1;
            end
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      exp_addr  <= '0;
      slot_q    <= '0;
      symb_q    <= '0;
      o_seq_err <= 1'b0;
      o_ovf     <= 1'b0;
      o_err_cnt <= '0;
      o_rd_en   <= 1'b0;
    end else begin
      state     <= state_n;
      exp_addr  <= exp_n;
      slot_q    <= slot_n;
      symb_q    <= symb_n;
      o_seq_err <= seq_err_n;
      o_ovf     <= ovf_n;
      o_rd_en   <= (count < CNT_AFULL);
      if ((seq_err_n || ovf_n) && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
    end
  end

  // The head entry stays in the FIFO until its upper half has been loaded.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      phase      <= 1'b0;
      k          <= '0;
      o_re_vld   <= 1'b0;
      o_re_data  <= '0;
      o_re_idx   <= '0;
      o_re_first <= 1'b0;
      o_re_last  <= 1'b0;
      o_slot_idx <= '0;
      o_symb_idx <= '0;
      o_agc      <= '0;
    end else if (load) begin
      if (!empty) begin
        o_re_vld   <= 1'b1;
        o_re_data  <= phase ? head.data[63:32] : head.data[31:0];
        o_re_idx   <= {k_eff, phase};
        o_re_first <= head.first & ~phase;
        o_re_last  <= head.last & phase;
        o_slot_idx <= head.slot;
        o_symb_idx <= head.symb;
        o_agc      <= head.agc;
        if (phase) begin
          phase <= 1'b0;
          k     <= k_eff + 7'd1;
        end else begin
          phase <= 1'b1;
        end
      end else begin
        o_re_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpri_rx_unpack.sv
// tb/tb_cpri_rx_unpack.sv - scoreboard bench for cpri_rx_unpack
module tb_cpri_rx_unpack;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_tvalid = 1'b0;
  logic [63:0] i_tx_data = '0;
  logic [6:0]  i_tx_addr = '0;
  logic        i_tx_last = 1'b0;
  logic [31:0] i_fft_agc = '0;
  logic        i_re_rdy = 1'b1;
  logic        o_rd_en, o_re_vld, o_re_first, o_re_last, o_seq_err, o_ovf;
  logic [31:0] o_re_data, o_agc;
  logic [7:0]  o_re_idx;
  logic [6:0]  o_slot_idx;
  logic [3:0]  o_symb_idx;
  logic [15:0] o_err_cnt;

  always #5 clk = ~clk;

  cpri_rx_unpack dut (
    .i_clk(clk), .i_reset(i_reset), .i_tvalid(i_tvalid), .i_tx_data(i_tx_data),
    .i_tx_addr(i_tx_addr), .i_tx_last(i_tx_last), .i_fft_agc(i_fft_agc),
    .o_rd_en(o_rd_en), .i_re_rdy(i_re_rdy), .o_re_vld(o_re_vld), .o_re_data(o_re_data),
    .o_re_idx(o_re_idx), .o_re_first(o_re_first), .o_re_last(o_re_last),
    .o_slot_idx(o_slot_idx), .o_symb_idx(o_symb_idx), .o_agc(o_agc),
    .o_seq_err(o_seq_err), .o_ovf(o_ovf), .o_err_cnt(o_err_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  idx;
    logic        first;
    logic        last;
    logic [6:0]  slot;
    logic [3:0]  symb;
    logic [31:0] agc;
  } re_t;

  re_t         q[$];
  int          total = 0;
  int          bad = 0;
  int          seq_seen = 0;
  int          ovf_seen = 0;
  int          rdy_mode = 0;
  int          stop_at = -1;
  bit          hit = 1'b0;
  bit          obey = 1'b1;
  bit          rd_low = 1'b0;
  logic        prev_vld = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [31:0] prev_data = '0;
  logic [7:0]  prev_idx = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    re_t e;
    if (o_seq_err) seq_seen++;
    if (o_ovf) ovf_seen++;
    if (!o_rd_en && !i_reset) rd_low = 1'b1;
    if (stop_at >= 0 && o_re_vld && int'(o_re_idx) >= stop_at) hit = 1'b1;
    if (!i_reset && prev_vld && !prev_rdy) begin
      chk("hold_vld", 64'(o_re_vld), 64'(1'b1));
      chk("hold_data", 64'(o_re_data), 64'(prev_data));
      chk("hold_idx", 64'(o_re_idx), 64'(prev_idx));
    end
    if (o_re_vld && i_re_rdy) begin
      chk("sb_nonempty", 64'(q.size() != 0), 64'(1'b1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("re_data", 64'(o_re_data), 64'(e.data));
        chk("re_idx", 64'(o_re_idx), 64'(e.idx));
        chk("re_first", 64'(o_re_first), 64'(e.first));
        chk("re_last", 64'(o_re_last), 64'(e.last));
        chk("re_slot", 64'(o_slot_idx), 64'(e.slot));
        chk("re_symb", 64'(o_symb_idx), 64'(e.symb));
        chk("re_agc", 64'(o_agc), 64'(e.agc));
      end
    end
    prev_vld  = o_re_vld;
    prev_rdy  = i_re_rdy;
    prev_data = o_re_data;
    prev_idx  = o_re_idx;
  endtask

  task automatic step();
    sample();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       i_re_rdy = 1'b1;
      1:       i_re_rdy = ~i_re_rdy;
      default: i_re_rdy = 1'b0;
    endcase
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, 64'(o_re_vld), 64'(0));
    chk({tag, "_data"}, 64'(o_re_data), 64'(0));
    chk({tag, "_idx"}, 64'(o_re_idx), 64'(0));
    chk({tag, "_fl"}, 64'({o_re_first, o_re_last}), 64'(0));
    chk({tag, "_tag"}, 64'({o_slot_idx, o_symb_idx, o_agc}), 64'(0));
    chk({tag, "_err"}, 64'({o_seq_err, o_ovf, o_err_cnt}), 64'(0));
    chk({tag, "_rd_en"}, 64'(o_rd_en), 64'(0));
  endtask

  task automatic do_reset();
    i_reset  = 1'b1;
    i_tvalid = 1'b0;
    step();
    chk_zero("rst_a");
    step();
    chk_zero("rst_b");
    i_reset = 1'b0;
    q.delete();
    prev_vld = 1'b0;
    seq_seen = 0;
    ovf_seen = 0;
    rd_low   = 1'b0;
    stop_at  = -1;
    hit      = 1'b0;
    chk("rst_rd_en_low", 64'(o_rd_en), 64'(0));
    step();
    chk("rst_rd_en_rise", 64'(o_rd_en), 64'(1));
    chk("rst_fifo_empty", 64'(o_re_vld), 64'(0));
  endtask

  task automatic send_word(input int a, input logic [63:0] d);
    int w = 0;
    i_tvalid = 1'b0;
    if (obey) begin
      while (!o_rd_en && w < 500) begin
        step();
        w++;
      end
      if (w >= 500) chk("rd_en_wait", 64'(o_rd_en), 64'(1));
    end
    i_tvalid  = 1'b1;
    i_tx_addr = 7'(a);
    i_tx_data = d;
    i_tx_last = (a == 95);
    step();
    i_tvalid = 1'b0;
  endtask

  task automatic send_chip(input logic [6:0] slot, input logic [3:0] symb, input logic [31:0] agc,
                           input int start, input int skip, input int exp_upto);
    logic [63:0] d;
    re_t e;
    i_fft_agc = agc;
    for (int a = start; a <= 95; a++) begin
      if (a == skip) continue;
      d = {$urandom, $urandom};
      if (a == 3) begin
        d[18:12] = slot;
        d[11:8]  = symb;
      end
      if (a >= 4 && a <= exp_upto) begin
        for (int ph = 0; ph < 2; ph++) begin
          e.data  = (ph == 1) ? d[63:32] : d[31:0];
          e.idx   = 8'(2 * (a - 4) + ph);
          e.first = (a == 4) && (ph == 0);
          e.last  = (a == 95) && (ph == 1);
          e.slot  = slot;
          e.symb  = symb;
          e.agc   = agc;
          q.push_back(e);
        end
      end
      send_word(a, d);
      if (hit) break;
    end
  endtask

  task automatic drain();
    int n = 0;
    i_tvalid = 1'b0;
    while ((q.size() != 0 || o_re_vld) && n < 3000) begin
      step();
      n++;
    end
    chk("drain_done", 64'(q.size()), 64'(0));
    chk("drain_vld", 64'(o_re_vld), 64'(0));
  endtask

  initial begin
    #1;
    do_reset();

    // Clean chip with ready held high.
    rdy_mode = 0;
    send_chip(7'd5, 4'd2, 32'h1234_5678, 0, -1, 95);
    drain();
    chk("clean_err_cnt", 64'(o_err_cnt), 64'(0));
    chk("clean_seq", 64'(seq_seen), 64'(0));

    // Four back-to-back chips under 50% downstream ready.
    rdy_mode = 1;
    for (int c = 0; c < 4; c++) send_chip(7'(10 + c), 4'(c + 1), 32'hA000_0000 + 32'(c), 0, -1, 95);
    drain();
    chk("b2b_rd_fell", 64'(rd_low), 64'(1));
    chk("b2b_rd_recover", 64'(o_rd_en), 64'(1));
    chk("b2b_no_ovf", 64'(ovf_seen), 64'(0));
    chk("b2b_err_cnt", 64'(o_err_cnt), 64'(0));

    // Address jump 40 -> 42 inside payload.
    do_reset();
    rdy_mode = 0;
    send_chip(7'd33, 4'd7, 32'hDEAD_BEEF, 0, 41, 40);
    send_chip(7'd34, 4'd8, 32'hCAFE_0001, 0, -1, 95);
    drain();
    chk("jump_seq_pulses", 64'(seq_seen), 64'(1));
    chk("jump_err_cnt", 64'(o_err_cnt), 64'(1));

    // Overflow with downstream stalled and upstream ignoring read-enable.
    do_reset();
    rdy_mode = 2;
    obey = 1'b0;
    send_chip(7'd60, 4'd9, 32'h0BAD_F00D, 0, -1, 35);
    chk("ovf_pulses", 64'(ovf_seen), 64'(1));
    chk("ovf_no_seq", 64'(seq_seen), 64'(0));
    chk("ovf_err_cnt", 64'(o_err_cnt), 64'(1));
    obey = 1'b1;
    rdy_mode = 1;
    drain();
    send_chip(7'd61, 4'd10, 32'h0000_1111, 0, -1, 95);
    drain();
    chk("ovf_err_cnt_after", 64'(o_err_cnt), 64'(1));

    // Reset mid-payload once output reaches RE index 60.
    rdy_mode = 0;
    do_reset();
    stop_at = 60;
    send_chip(7'd77, 4'd3, 32'h5555_AAAA, 0, -1, 95);
    chk("mid_hit", 64'(hit), 64'(1));
    do_reset();
    send_chip(7'd78, 4'd4, 32'h7777_0000, 0, -1, 95);
    drain();
    chk("mid_err_cnt", 64'(o_err_cnt), 64'(0));

    // Chip entering IDLE at address 7 is ignored.
    do_reset();
    send_chip(7'd90, 4'd11, 32'hFFFF_0000, 7, -1, 0);
    send_chip(7'd91, 4'd12, 32'h0123_4567, 0, -1, 95);
    drain();
    chk("idle_seq", 64'(seq_seen), 64'(0));
    chk("idle_err_cnt", 64'(o_err_cnt), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
